fixed_point_alu: RTL and testbench

- Multi-cycle signed fixed-point ALU, format Q(INTEGER_PART_WIDTH).(FRACTIONAL_PART_WIDTH), two's complement.
- Serves as the arithmetic engine of the RPN stack machine in the function plotter.
- Performs add, subtract, multiply, divide and integer power under a start/done handshake.
- Every result saturates to the representable range.

---
 rtl/fixed_point_pkg.sv | 31 +++
 rtl/fixed_point_alu_if.sv | 17 +
 rtl/fixed_point_divider.sv | 61 ++++++
 rtl/fixed_point_alu.sv | 196 +++++++++++++++++++
 tb/tb_fixed_point_alu.sv | 133 +++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point ALU: op encoding, FSM states and saturation.
package fixed_point_pkg;

  // Operator codes; the stack machine reserves 3'd6 for VAR
  localparam logic [2:0] PLUS = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] POW  = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_ITER = 3'd1,
    DIV_ITER = 3'd2,
    POW_ITER = 3'd3,
    FINISH   = 3'd4
  } alu_state_e;

  // Clamp a wide signed value into the range of an n-bit two's complement word
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fixed_point_alu_if.sv
// Request/response bundle between the stack machine and the fixed-point ALU.
interface fixed_point_alu_if #(
  parameter int unsigned INTEGER_PART_WIDTH    = 8,
  parameter int unsigned FRACTIONAL_PART_WIDTH = 8
);
  localparam int unsigned N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;

  logic                start;
  logic [2:0]          op;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic                done;
  logic signed [N-1:0] result;

  modport master (output start, op, a, b, input done, result);
  modport slave  (input start, op, a, b, output done, result);
endinterface

// File: rtl/fixed_point_divider.sv
// Restoring divider: quotient = (dividend << F) / divisor on magnitudes, one bit per cycle.
module fixed_point_divider #(
  parameter int unsigned N = 16,
  parameter int unsigned F = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   dividend,
  input  logic [N-1:0]   divisor,
  output logic [N+F-1:0] quotient,
  output logic           done
);
  localparam int unsigned QW = N + F;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [N-1:0]  rem;
  logic [N-1:0]  divisor_q;
  logic [CW-1:0] count;
  logic          busy;
  logic [N:0]    rem_shift;
  logic [N:0]    rem_sub;

  // quotient doubles as the dividend shift register; bits leave the top, quotient bits enter the bottom
  assign rem_shift = {rem, quotient[QW-1]};
  assign rem_sub   = rem_shift - {1'b0, divisor_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      rem       <= '0;
      divisor_q <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= {dividend, {F{1'b0}}};
        rem       <= '0;
        divisor_q <= divisor;
        count     <= CW'(QW);
        busy      <= 1'b1;
      end else if (busy) begin
        if (!rem_sub[N]) begin
          rem      <= rem_sub[N-1:0];
          quotient <= {quotient[QW-2:0], 1'b1};
        end else begin
          rem      <= rem_shift[N-1:0];
          quotient <= {quotient[QW-2:0], 1'b0};
        end
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fixed_point_alu.sv
// Multi-cycle saturating Q(I).(F) ALU: add, subtract, multiply, divide and integer power.
module fixed_point_alu
  import fixed_point_pkg::*;
#(
  parameter int unsigned INTEGER_PART_WIDTH    = 8,
  parameter int unsigned FRACTIONAL_PART_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  fixed_point_alu_if.slave bus
);
  localparam int unsigned I  = INTEGER_PART_WIDTH;
  localparam int unsigned F  = FRACTIONAL_PART_WIDTH;
  localparam int unsigned N  = I + F;
  localparam int unsigned BW = (I > 1) ? $clog2(I) : 1;
  localparam logic signed [N-1:0] ONE  = N'(64'd1 << F);
  localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  alu_state_e          state, state_next;
  logic                done_q, done_next;
  logic signed [N-1:0] result_q, result_next;
  logic signed [N-1:0] acc, acc_next;
  logic signed [N-1:0] base, base_next;
  logic [I-1:0]        exp_mag, exp_next;
  logic [BW-1:0]       bit_idx, bit_next;
  logic                phase, phase_next;
  logic                pow_neg, pow_neg_next;
  logic                neg_q, neg_q_next;

  logic                div_go;
  logic [N-1:0]        div_dvd;
  logic [N-1:0]        div_dvs;
  logic [N+F-1:0]      div_quot;
  logic                div_done;

  logic signed [N:0]     sum_add, sum_sub;
  logic [N-1:0]          a_mag, b_mag;
  logic [I-1:0]          exp_raw, exp_abs;
  logic signed [N-1:0]   mul_y, mul_sat, pow_acc;
  logic signed [2*N-1:0] product;
  logic signed [N+F:0]   q_signed;

  assign bus.done   = done_q;
  assign bus.result = result_q;

  assign sum_add = (N+1)'(bus.a) + (N+1)'(bus.b);
  assign sum_sub = (N+1)'(bus.a) - (N+1)'(bus.b);
  assign a_mag   = bus.a[N-1] ? N'(-bus.a) : N'(bus.a);
  assign b_mag   = bus.b[N-1] ? N'(-bus.b) : N'(bus.b);
  assign exp_raw = bus.b[N-1:F];
  assign exp_abs = exp_raw[I-1] ? I'(-exp_raw) : exp_raw;

  // Single shared multiplier: MUL uses acc*base, POW alternates square and multiply-by-base
  assign mul_y   = (state == POW_ITER && !phase) ? acc : base;
  assign product = (2*N)'(acc) * (2*N)'(mul_y);
  assign mul_sat = N'(saturate(64'(product >>> F), N));

  assign q_signed = neg_q ? -$signed({1'b0, div_quot}) : $signed({1'b0, div_quot});

  fixed_point_divider #(.N(N), .F(F)) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_go),
    .dividend (div_dvd),
    .divisor  (div_dvs),
    .quotient (div_quot),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done_q   <= 1'b1;
      result_q <= '0;
      acc      <= '0;
      base     <= '0;
      exp_mag  <= '0;
      bit_idx  <= '0;
      phase    <= 1'b0;
      pow_neg  <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state    <= state_next;
      done_q   <= done_next;
      result_q <= result_next;
      acc      <= acc_next;
      base     <= base_next;
      exp_mag  <= exp_next;
      bit_idx  <= bit_next;
      phase    <= phase_next;
      pow_neg  <= pow_neg_next;
      neg_q    <= neg_q_next;
    end
  end

  always_comb begin
    state_next   = state;
    done_next    = done_q;
    result_next  = result_q;
    acc_next     = acc;
    base_next    = base;
    exp_next     = exp_mag;
    bit_next     = bit_idx;
    phase_next   = phase;
    pow_neg_next = pow_neg;
    neg_q_next   = neg_q;
    div_go       = 1'b0;
    div_dvd      = a_mag;
    div_dvs      = b_mag;
    pow_acc      = acc;

    case (state)
      IDLE: begin
        if (bus.start) begin
          done_next  = 1'b0;
          state_next = FINISH;
          case (bus.op)
            PLUS: acc_next = N'(saturate(64'(sum_add), N));
            SUB:  acc_next = N'(saturate(64'(sum_sub), N));
            MUL: begin
              acc_next   = bus.a;
              base_next  = bus.b;
              state_next = MUL_ITER;
            end
            DIV: begin
              if (bus.b == '0) begin
                acc_next = (bus.a == '0) ? '0 : (bus.a[N-1] ? SMIN : SMAX);
              end else begin
                div_go     = 1'b1;
                neg_q_next = bus.a[N-1] ^ bus.b[N-1];
                state_next = DIV_ITER;
              end
            end
            POW: begin
              acc_next     = ONE;
              base_next    = bus.a;
              exp_next     = exp_abs;
              pow_neg_next = exp_raw[I-1];
              bit_next     = BW'(I - 1);
              phase_next   = 1'b0;
              state_next   = POW_ITER;
            end
            default: acc_next = '0;
          endcase
        end
      end
      MUL_ITER: begin
        result_next = mul_sat;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      POW_ITER: begin
        if (!phase) begin
          acc_next   = mul_sat;
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          pow_acc    = exp_mag[bit_idx] ? mul_sat : acc;
          acc_next   = pow_acc;
          if (bit_idx == '0) begin
            state_next = FINISH;
            // Negative exponent: reciprocal through the divider; 1.0/0 saturates high
            if (pow_neg) begin
              if (pow_acc == '0) begin
                acc_next = SMAX;
              end else begin
                div_go     = 1'b1;
                div_dvd    = N'(ONE);
                div_dvs    = pow_acc[N-1] ? N'(-pow_acc) : N'(pow_acc);
                neg_q_next = pow_acc[N-1];
                state_next = DIV_ITER;
              end
            end
          end else begin
            bit_next = bit_idx - BW'(1);
          end
        end
      end
      DIV_ITER: begin
        if (div_done) begin
          result_next = N'(saturate(64'(q_signed), N));
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      FINISH: begin
        result_next = acc;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fixed_point_alu.sv
// Directed self-checking bench for fixed_point_alu at Q8.8.
module tb_fixed_point_alu;
  import fixed_point_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   lat;

  always #5 clk = ~clk;

  fixed_point_alu_if #(.INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8)) bus ();

  fixed_point_alu #(.INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Present a request on the current cycle; the next rising edge is the start edge
  task automatic pulse(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] expv, output int cycles);
    pulse(op, a, b);
    check({tag, "_busy"}, 16'(bus.done), 16'd0);
    wait_done(cycles);
    check({tag, "_done"}, 16'(bus.done), 16'd1);
    check(tag, bus.result, expv);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 16'(bus.done), 16'd1);
    check("rst_result", bus.result, 16'h0000);
    rst = 1'b0;

    run_op("plus", PLUS, 16'h0380, 16'h0140, 16'h04C0, lat);
    check("plus_lat", 16'(lat), 16'd1);
    run_op("sub", SUB, 16'h6400, 16'h7FFF, 16'hE401, lat);
    check("sub_lat", 16'(lat), 16'd1);
    run_op("sub_sat_lo", SUB, 16'h8000, 16'h0100, 16'h8000, lat);
    run_op("plus_sat_hi", PLUS, 16'h7F00, 16'h7F00, 16'h7FFF, lat);

    run_op("mul", MUL, 16'h0280, 16'hFC00, 16'hF600, lat);
    check("mul_lat_ok", 16'(lat <= 17), 16'd1);
    run_op("mul_sat", MUL, 16'h4000, 16'h0400, 16'h7FFF, lat);

    run_op("div", DIV, 16'h0700, 16'h0200, 16'h0380, lat);
    check("div_lat_ok", 16'(lat <= 26), 16'd1);
    run_op("div_neg", DIV, 16'hF900, 16'h0200, 16'hFC80, lat);
    run_op("div_pos_by0", DIV, 16'h0100, 16'h0000, 16'h7FFF, lat);
    check("div_by0_lat", 16'(lat), 16'd1);
    run_op("div_neg_by0", DIV, 16'hFF00, 16'h0000, 16'h8000, lat);
    run_op("div_0_by0", DIV, 16'h0000, 16'h0000, 16'h0000, lat);

    run_op("pow3", POW, 16'h0180, 16'h0300, 16'h0360, lat);
    run_op("pow0", POW, 16'h0180, 16'h0000, 16'h0100, lat);
    run_op("pow_m1", POW, 16'h0200, 16'hFF00, 16'h0080, lat);
    check("pow_lat_ok", 16'(lat <= 58), 16'd1);

    run_op("invalid_op", 3'b101, 16'h1234, 16'h5678, 16'h0000, lat);
    check("invalid_lat", 16'(lat), 16'd1);

    // A second request while a divide is in flight must be dropped
    pulse(DIV, 16'h0700, 16'h0200);
    repeat (3) @(posedge clk);
    #1;
    pulse(PLUS, 16'h0100, 16'h0100);
    wait_done(lat);
    check("ignored_done", 16'(bus.done), 16'd1);
    check("ignored_result", bus.result, 16'h0380);
    @(posedge clk);
    #1;
    check("ignored_hold_done", 16'(bus.done), 16'd1);
    check("ignored_hold_result", bus.result, 16'h0380);

    // Reset in the middle of a divide aborts it
    pulse(DIV, 16'h0700, 16'h0200);
    repeat (4) @(posedge clk);
    #1;
    check("mid_div_busy", 16'(bus.done), 16'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_done", 16'(bus.done), 16'd1);
    check("abort_result", bus.result, 16'h0000);
    repeat (30) @(posedge clk);
    #1;
    check("abort_stays_result", bus.result, 16'h0000);

    run_op("post_abort_plus", PLUS, 16'h0380, 16'h0140, 16'h04C0, lat);
    run_op("b2b_mul", MUL, 16'h0280, 16'hFC00, 16'hF600, lat);
    run_op("b2b_sub", SUB, 16'h0100, 16'h0200, 16'hFF00, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
